// File: rtl/wslce_seq_gen_if.sv
// rtl/wslce_seq_gen_if.sv - configuration/handshake bundle for the Legendre sequence generator
interface wslce_seq_gen_if #(
    parameter int NMAX = 127,
    parameter int W    = $clog2(NMAX + 1)
);
    logic            start;
    logic [W-1:0]    prime_n;
    logic [W-1:0]    root_g;
    logic [W-1:0]    shift_k;
    logic            busy;
    logic            done;
    logic            err;
    logic [NMAX-1:0] slce_out;
    logic [NMAX-1:0] wslce_k;
    logic [W-1:0]    ones_count;

    modport master (
        output start, prime_n, root_g, shift_k,
        input  busy, done, err, slce_out, wslce_k, ones_count
    );

    modport slave (
        input  start, prime_n, root_g, shift_k,
        output busy, done, err, slce_out, wslce_k, ones_count
    );
endinterface

// File: rtl/wslce_seq_gen.sv
// rtl/wslce_seq_gen.sv - iterative Legendre-type sequence and XOR-weighted sequence generator
module wslce_seq_gen #(
    parameter int NMAX = 127,
    parameter int W    = $clog2(NMAX + 1)
) (
    input logic           clk,
    input logic           rst,
    wslce_seq_gen_if.slave bus
);
    localparam int BW = $clog2(W);
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_QNR   = 3'd2;
    localparam logic [2:0] S_SEQ   = 3'd3;
    localparam logic [2:0] S_XOR   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]      state;
    logic [W-1:0]    n_reg, g_reg, k_reg;
    logic [W-1:0]    acc;
    logic [W-1:0]    r;
    logic [W-1:0]    g_sh;
    logic [BW-1:0]   bit_cnt;
    logic [W-1:0]    step;
    logic [NMAX-1:0] qnr;
    logic [NMAX-1:0] slce_reg, wslce_reg;
    logic [W-1:0]    ones_reg;
    logic            err_r;
    logic [NMAX-1:0] slce_out_r, wslce_out_r;
    logic [W-1:0]    ones_out_r;

    logic [W:0]      nx, dbl, dbl_red, sum, aplus, jk;
    logic [W-1:0]    mul_next, qnr_idx, xor_idx, n_last;
    logic            qnr_bit, xor_bit, mul_last, cfg_bad;
    logic [NMAX-1:0] wslce_fin;

    // One Blakley step per cycle: r = 2r mod N, then + acc mod N when the current g bit is set.
    always_comb begin
        nx       = {1'b0, n_reg};
        n_last   = n_reg - W'(1);
        dbl      = {r, 1'b0};
        dbl_red  = (dbl >= nx) ? dbl - nx : dbl;
        sum      = dbl_red + {1'b0, acc};
        if (g_sh[W-1]) mul_next = (sum >= nx) ? W'(sum - nx) : W'(sum);
        else           mul_next = W'(dbl_red);
        mul_last = (bit_cnt == LAST_BIT);
        aplus    = {1'b0, acc} + (W+1)'(1);
        qnr_idx  = (aplus == nx) ? '0 : W'(aplus);
        qnr_bit  = qnr[qnr_idx];
        jk       = {1'b0, step} + {1'b0, k_reg};
        xor_idx  = (jk >= nx) ? W'(jk - nx) : W'(jk);
        xor_bit  = slce_reg[step] ^ slce_reg[xor_idx];
        wslce_fin = wslce_reg | (NMAX'(xor_bit) << step);
        cfg_bad  = (n_reg < W'(3)) || (nx > (W+1)'(NMAX)) || (g_reg == '0) ||
                   (g_reg >= n_reg) || (k_reg >= n_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            n_reg       <= '0;
            g_reg       <= '0;
            k_reg       <= '0;
            acc         <= '0;
            r           <= '0;
            g_sh        <= '0;
            bit_cnt     <= '0;
            step        <= '0;
            qnr         <= '0;
            slce_reg    <= '0;
            wslce_reg   <= '0;
            ones_reg    <= '0;
            err_r       <= 1'b0;
            slce_out_r  <= '0;
            wslce_out_r <= '0;
            ones_out_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        n_reg <= bus.prime_n;
                        g_reg <= bus.root_g;
                        k_reg <= bus.shift_k;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cfg_bad) begin
                        err_r       <= 1'b1;
                        slce_out_r  <= '0;
                        wslce_out_r <= '0;
                        ones_out_r  <= '0;
                        state       <= S_DONE;
                    end else begin
                        qnr       <= '0;
                        slce_reg  <= '0;
                        wslce_reg <= '0;
                        ones_reg  <= '0;
                        acc       <= W'(1);
                        r         <= '0;
                        g_sh      <= g_reg;
                        bit_cnt   <= '0;
                        step      <= W'(1);
                        state     <= S_QNR;
                    end
                end
                S_QNR, S_SEQ: begin
                    if (!mul_last) begin
                        bit_cnt <= bit_cnt + BW'(1);
                        r       <= mul_next;
                        g_sh    <= g_sh << 1;
                    end else begin
                        bit_cnt <= '0;
                        r       <= '0;
                        g_sh    <= g_reg;
                        if (state == S_QNR) begin
                            if (step[0]) qnr[mul_next] <= 1'b1;
                            // A return to 1 before step N-1 (or a miss at N-1) means g is not a generator.
                            if ((step == n_last) ? (mul_next != W'(1)) : (mul_next == W'(1))) begin
                                err_r       <= 1'b1;
                                slce_out_r  <= '0;
                                wslce_out_r <= '0;
                                ones_out_r  <= '0;
                                state       <= S_DONE;
                            end else if (step == n_last) begin
                                acc   <= W'(1);
                                step  <= '0;
                                state <= S_SEQ;
                            end else begin
                                acc  <= mul_next;
                                step <= step + W'(1);
                            end
                        end else begin
                            slce_reg[step] <= qnr_bit;
                            ones_reg       <= ones_reg + W'(qnr_bit);
                            acc            <= mul_next;
                            if (step == n_last) begin
                                step  <= '0;
                                state <= S_XOR;
                            end else begin
                                step <= step + W'(1);
                            end
                        end
                    end
                end
                S_XOR: begin
                    wslce_reg <= wslce_fin;
                    if (step == n_last) begin
                        err_r       <= 1'b0;
                        slce_out_r  <= slce_reg;
                        wslce_out_r <= wslce_fin;
                        ones_out_r  <= ones_reg;
                        state       <= S_DONE;
                    end else begin
                        step <= step + W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state == S_CHECK) || (state == S_QNR) ||
                            (state == S_SEQ) || (state == S_XOR);
    assign bus.done       = (state == S_DONE);
    assign bus.err        = err_r;
    assign bus.slce_out   = slce_out_r;
    assign bus.wslce_k    = wslce_out_r;
    assign bus.ones_count = ones_out_r;
endmodule
